// File: rtl/grey_pkg.sv
// Shared types and the shift-add luma helper
// for the bit-serial RGB->grey datapath.
package grey_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        EMIT,
        DONE
    } state_e;

    localparam int PIX_W = 8;
    localparam int SUM_W = 10;

    // grey ~= (r+g+b)/3 as sum/4 + sum/16 + sum/64 + sum/256.
    // The maximum result is 251, so the top sum bits always drop out.
    function automatic logic [PIX_W-1:0] grey_of(
        input logic [PIX_W-1:0] r,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] b
    );
        logic [SUM_W-1:0] s;
        logic [SUM_W-1:0] t;
        s = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
        t = (s >> 2) + (s >> 4) + (s >> 6) + (s >> 8);
        return t[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/grey_luma_calc.sv
// Combinational luma and threshold stage:
// r/g/b in, grey and black flag out.
module grey_luma_calc
    import grey_pkg::*;
#(
    parameter int unsigned THRESH = 100
) (
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] grey_o,
    output logic             black_o
);

    assign grey_o  = grey_of(r_i, g_i, b_i);
    assign black_o = (32'(grey_o) > THRESH);

endmodule

// File: rtl/grey_pixel_sequencer.sv
// Frame controller: loads serial RGB bits, computes grey,
// emits it MSB first and walks col/row over the frame.
module grey_pixel_sequencer
    import grey_pkg::*;
#(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned THRESH = 100,
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic          pred,
    input  logic          pgreen,
    input  logic          pblue,
    output logic          in_ready,
    output logic          grey_bit,
    output logic          grey_valid,
    input  logic          out_ready,
    output logic          black,
    output logic          black_valid,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          busy,
    output logic          frame_done
);

    state_e           state_q;
    logic [2:0]       bitcnt_q;
    logic [PIX_W-1:0] r_q;
    logic [PIX_W-1:0] g_q;
    logic [PIX_W-1:0] b_q;
    logic [PIX_W-1:0] grey_q;
    logic             black_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;

    logic [PIX_W-1:0] grey_w;
    logic             black_w;

    grey_luma_calc #(
        .THRESH (THRESH)
    ) u_luma (
        .r_i    (r_q),
        .g_i    (g_q),
        .b_i    (b_q),
        .grey_o (grey_w),
        .black_o(black_w)
    );

    logic emit;
    assign emit = (state_q == EMIT);

    assign in_ready    = (state_q == LOAD);
    assign grey_valid  = emit;
    assign black_valid = emit;
    assign grey_bit    = emit & grey_q[3'd7 - bitcnt_q];
    assign black       = black_q;
    assign col         = col_q;
    assign row         = row_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == DONE);

    logic last_col;
    logic last_row;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    // Pixel sequencing: load bits, latch grey, emit, step col/row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            grey_q   <= '0;
            black_q  <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    bitcnt_q <= '0;
                    if (start) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_q[bitcnt_q] <= pred;
                        g_q[bitcnt_q] <= pgreen;
                        b_q[bitcnt_q] <= pblue;
                        bitcnt_q      <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    grey_q  <= grey_w;
                    black_q <= black_w;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            black_q <= 1'b0;
                            if (last_col) begin
                                col_q <= '0;
                                if (last_row) begin
                                    row_q   <= '0;
                                    state_q <= DONE;
                                end else begin
                                    row_q   <= row_q + RW'(1);
                                    state_q <= LOAD;
                                end
                            end else begin
                                col_q   <= col_q + CW'(1);
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grey_pixel_sequencer.sv
// Scoreboard bench for grey_pixel_sequencer on a 3x2 frame:
// stimulus queues expected pixels, a monitor checks emitted ones.
module tb_grey_pixel_sequencer;

    localparam int W = 3;
    localparam int H = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       pred;
    logic       pgreen;
    logic       pblue;
    logic       in_ready;
    logic       grey_bit;
    logic       grey_valid;
    logic       out_ready;
    logic       black;
    logic       black_valid;
    logic [1:0] col;
    logic       row;
    logic       busy;
    logic       frame_done;

    grey_pixel_sequencer #(
        .IMG_W (W),
        .IMG_H (H),
        .THRESH(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .pred       (pred),
        .pgreen     (pgreen),
        .pblue      (pblue),
        .in_ready   (in_ready),
        .grey_bit   (grey_bit),
        .grey_valid (grey_valid),
        .out_ready  (out_ready),
        .black      (black),
        .black_valid(black_valid),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] grey;
        logic       black;
        int         col;
        int         row;
        bit         last;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;
    int   pix;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({in_ready, grey_bit, grey_valid, black,
                     black_valid, busy, frame_done, col, row});
    endfunction

    task automatic send_pixel(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input logic [7:0] gr,
        input bit         gaps,
        input int         nbits
    );
        exp_t e;
        int   k;
        e.grey  = gr;
        e.black = (gr > 8'd100);
        e.col   = pix % W;
        e.row   = pix / W;
        e.last  = (pix == W * H - 1);
        sb.push_back(e);
        pix = (pix + 1) % (W * H);
        for (int i = 0; i < nbits; i++) begin
            k = 0;
            while (!in_ready && k < 200) begin
                tick();
                k++;
            end
            if (!in_ready) begin
                tests++;
                fails++;
                $display("FAIL load_wait: in_ready got 0 expected 1");
                return;
            end
            in_valid = 1'b1;
            pred     = r[i];
            pgreen   = g[i];
            pblue    = b[i];
            tick();
            in_valid = 1'b0;
            if (gaps && i < 7) begin
                pred   = ~r[i];
                pgreen = ~g[i];
                pblue  = ~b[i];
                tick();
            end
        end
    endtask

    task automatic start_frame();
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        chk("idle_before_start", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        pix = 0;
        chk(name, all_outs(), 0);
    endtask

    task automatic wait_emit();
        int k;
        k = 0;
        while (!grey_valid && k < 50) begin
            tick();
            k++;
        end
        chk("emit_reached", int'(grey_valid), 1);
    endtask

    // Monitor: gathers emitted bits and checks against the queue.
    int         nb;
    logic [7:0] acc;
    bit         pgv;
    bit         por;
    bit         pbit;
    int         done_chk;

    initial begin
        exp_t e;
        nb       = 0;
        acc      = '0;
        pgv      = 0;
        por      = 0;
        pbit     = 0;
        done_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nb       = 0;
                pgv      = 0;
                done_chk = 0;
            end else begin
                if (done_chk == 1) begin
                    chk("frame_done_pulse", int'({frame_done, busy}), 3);
                    done_chk = 2;
                end else if (done_chk == 2) begin
                    chk("after_done_idle", int'({frame_done, busy}), 0);
                    done_chk = 0;
                end else if (frame_done) begin
                    chk("stray_frame_done", int'(frame_done), 0);
                end
                if (pgv && !por && grey_valid) begin
                    chk("stall_hold_bit", int'(grey_bit), int'(pbit));
                end
                if (grey_valid) begin
                    chk("black_valid_in_emit", int'(black_valid), 1);
                end
                if (grey_valid && out_ready) begin
                    acc = {acc[6:0], grey_bit};
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        tests++;
                        if (sb.size() == 0) begin
                            fails++;
                            $display("FAIL pixel_unexpected: grey %0d", acc);
                        end else begin
                            e = sb.pop_front();
                            if (acc !== e.grey || black !== e.black ||
                                int'(col) != e.col || int'(row) != e.row) begin
                                fails++;
                                $display("FAIL pixel: got g=%0d k=%0d c=%0d r=%0d expected g=%0d k=%0d c=%0d r=%0d",
                                         acc, black, col, row,
                                         e.grey, e.black, e.col, e.row);
                            end
                            if (e.last) done_chk = 1;
                        end
                    end
                end
                pgv  = grey_valid;
                por  = out_ready;
                pbit = grey_bit;
            end
        end
    end

    logic [7:0] fr[6] = '{8'h60, 8'h78, 8'hFF, 8'h00, 8'd104, 8'd108};
    logic [7:0] fg[6] = '{8'h60, 8'h78, 8'hFF, 8'h00, 8'd100, 8'd100};
    logic [7:0] fb[6] = '{8'h60, 8'h78, 8'hFF, 8'h00, 8'd100, 8'd100};
    logic [7:0] fy[6] = '{8'd95, 8'd118, 8'd251, 8'd0, 8'd100, 8'd101};

    logic [7:0] sr[6] = '{8'd10, 8'h87, 8'hFF, 8'h80, 8'h90, 8'h60};
    logic [7:0] sg[6] = '{8'd20, 8'h87, 8'h00, 8'h40, 8'h90, 8'h60};
    logic [7:0] sbl[6] = '{8'd30, 8'h87, 8'h00, 8'h20, 8'h60, 8'h60};
    logic [7:0] sy[6] = '{8'd18, 8'd133, 8'd81, 8'd73, 8'd127, 8'd95};

    initial begin
        int k;
        tests     = 0;
        fails     = 0;
        pix       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        pred      = 1'b0;
        pgreen    = 1'b0;
        pblue     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset_state", all_outs(), 0);
        rst = 1'b0;
        tick();

        // Frame 1: latency of the first pixel, then value/threshold vectors.
        start_frame();
        send_pixel(fr[0], fg[0], fb[0], fy[0], 0, 8);
        chk("calc_cycle", int'({grey_valid, in_ready}), 0);
        tick();
        chk("first_emit", int'(grey_valid), 1);
        chk("first_bit_msb", int'(grey_bit), 0);
        repeat (8) tick();
        chk("reload_after_17", int'({in_ready, grey_valid}), 2);
        for (int i = 1; i < 6; i++) begin
            send_pixel(fr[i], fg[i], fb[i], fy[i], 0, 8);
        end

        // Frame 2: input gaps, output stalls, start while busy.
        start_frame();
        send_pixel(sr[0], sg[0], sbl[0], sy[0], 1, 8);
        send_pixel(sr[1], sg[1], sbl[1], sy[1], 1, 8);
        wait_emit();
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_pixel(sr[2], sg[2], sbl[2], sy[2], 0, 8);
        send_pixel(sr[3], sg[3], sbl[3], sy[3], 0, 8);
        send_pixel(sr[4], sg[4], sbl[4], sy[4], 1, 8);
        wait_emit();
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        send_pixel(sr[5], sg[5], sbl[5], sy[5], 0, 8);

        // Resets mid-LOAD and mid-EMIT, then a fresh pixel from (0,0).
        start_frame();
        send_pixel(8'hFF, 8'hFF, 8'hFF, 8'd251, 0, 4);
        do_reset("reset_mid_load");
        start_frame();
        send_pixel(fr[1], fg[1], fb[1], fy[1], 0, 8);
        send_pixel(fr[2], fg[2], fb[2], fy[2], 0, 8);
        wait_emit();
        repeat (3) tick();
        do_reset("reset_mid_emit");

        // start together with rst, and in_valid while idle.
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        chk("start_rst_same_cycle", all_outs(), 0);
        tick();
        chk("still_idle", int'(busy), 0);
        in_valid = 1'b1;
        pred     = 1'b1;
        pgreen   = 1'b1;
        pblue    = 1'b1;
        repeat (4) tick();
        chk("no_ready_in_idle", int'(in_ready), 0);
        in_valid = 1'b0;

        // Frame 4: full frame after the resets.
        start_frame();
        for (int i = 0; i < 6; i++) begin
            send_pixel(fr[i], fg[i], fb[i], fy[i], 0, 8);
        end

        k = 0;
        while ((sb.size() > 0 || busy) && k < 500) begin
            tick();
            k++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_idle", int'(busy), 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
